// File: rtl/array_port_ctrl.sv
// rtl/array_port_ctrl.sv - clear-then-arbitrate controller for a single-port 128x74 array macro
module array_port_ctrl #(
    parameter int DEPTH        = 128,
    parameter int WIDTH        = 74,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_w_valid,
    output logic                     io_w_ready,
    input  logic [$clog2(DEPTH)-1:0] io_w_bits_addr,
    input  logic [1:0]               io_w_bits_mask,
    input  logic [WIDTH-1:0]         io_w_bits_data,
    input  logic                     io_r_req_valid,
    output logic                     io_r_req_ready,
    input  logic [$clog2(DEPTH)-1:0] io_r_req_bits_addr,
    output logic                     io_r_resp_valid,
    input  logic                     io_r_resp_ready,
    output logic [WIDTH-1:0]         io_r_resp_bits_data,
    output logic                     io_init_done,
    output logic [$clog2(DEPTH)-1:0] array_addr,
    output logic                     array_en,
    output logic                     array_wmode,
    output logic [1:0]               array_wmask,
    output logic [WIDTH-1:0]         array_wdata,
    input  logic [WIDTH-1:0]         array_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    sweep_cnt;
    logic             init_done_q;

    // Two-entry response queue; credits keep occ + inflight <= 2.
    logic [WIDTH-1:0] q_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic             inflight;
    logic [SW-1:0]    starve_cnt;

    logic             in_run;
    logic             in_init;
    logic             deq;
    logic [1:0]       outstanding;
    logic             read_elig;
    logic             starved;
    logic             write_grant;
    logic             read_grant;

    // Outputs are forced quiet while reset is asserted, even mid-sweep.
    assign in_run  = !reset && (state == ST_RUN);
    assign in_init = !reset && (state == ST_INIT);

    // A dequeue in the same cycle frees a slot, which sustains one read per cycle.
    assign deq         = in_run && (occ != 2'd0) && io_r_resp_ready;
    assign outstanding = occ + {1'b0, inflight} - {1'b0, deq};
    assign read_elig   = in_run && io_r_req_valid && (outstanding < 2'd2);
    assign starved     = (starve_cnt == SW'(STARVE_LIMIT));
    assign write_grant = in_run && io_w_valid && (!read_elig || starved);
    assign read_grant  = read_elig && !write_grant;

    assign io_w_ready          = write_grant;
    assign io_r_req_ready      = read_grant;
    assign io_r_resp_valid     = !reset && (occ != 2'd0);
    assign io_r_resp_bits_data = reset ? '0 : q_mem[rd_ptr];
    assign io_init_done        = !reset && init_done_q;

    // Drive the macro port: clear sweep, granted write, granted read, or idle zeros.
    always_comb begin
        array_en    = 1'b0;
        array_wmode = 1'b0;
        array_addr  = '0;
        array_wmask = 2'b00;
        array_wdata = '0;
        if (in_init) begin
            array_en    = 1'b1;
            array_wmode = 1'b1;
            array_wmask = 2'b11;
            array_addr  = sweep_cnt;
        end else if (write_grant) begin
            array_en    = 1'b1;
            array_wmode = 1'b1;
            array_wmask = io_w_bits_mask;
            array_addr  = io_w_bits_addr;
            array_wdata = io_w_bits_data;
        end else if (read_grant) begin
            array_en    = 1'b1;
            array_addr  = io_r_req_bits_addr;
        end
    end

    // Sweep every address with zeros after reset, then enter normal operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_INIT;
            sweep_cnt   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == AW'(DEPTH - 1)) begin
                        state       <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_RUN;
                    init_done_q <= 1'b1;
                end
            endcase
        end
    end

    // Track the in-flight read, capture macro data, and count write starvation.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            inflight <= read_grant;
            if (inflight) begin
                q_mem[wr_ptr] <= array_rdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, deq};
            if (write_grant) begin
                starve_cnt <= '0;
            end else if (in_run && io_w_valid && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_array_port_ctrl.sv
// tb/tb_array_port_ctrl.sv - randomized and directed checks of array_port_ctrl against a queue-based model
module tb_array_port_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_w_valid = 1'b0;
    logic        io_w_ready;
    logic [6:0]  io_w_bits_addr = '0;
    logic [1:0]  io_w_bits_mask = '0;
    logic [73:0] io_w_bits_data = '0;
    logic        io_r_req_valid = 1'b0;
    logic        io_r_req_ready;
    logic [6:0]  io_r_req_bits_addr = '0;
    logic        io_r_resp_valid;
    logic        io_r_resp_ready = 1'b0;
    logic [73:0] io_r_resp_bits_data;
    logic        io_init_done;
    logic [6:0]  array_addr;
    logic        array_en;
    logic        array_wmode;
    logic [1:0]  array_wmask;
    logic [73:0] array_wdata;
    logic [73:0] array_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    array_port_ctrl dut (
        .clock               (clock),
        .reset               (reset),
        .io_w_valid          (io_w_valid),
        .io_w_ready          (io_w_ready),
        .io_w_bits_addr      (io_w_bits_addr),
        .io_w_bits_mask      (io_w_bits_mask),
        .io_w_bits_data      (io_w_bits_data),
        .io_r_req_valid      (io_r_req_valid),
        .io_r_req_ready      (io_r_req_ready),
        .io_r_req_bits_addr  (io_r_req_bits_addr),
        .io_r_resp_valid     (io_r_resp_valid),
        .io_r_resp_ready     (io_r_resp_ready),
        .io_r_resp_bits_data (io_r_resp_bits_data),
        .io_init_done        (io_init_done),
        .array_addr          (array_addr),
        .array_en            (array_en),
        .array_wmode         (array_wmode),
        .array_wmask         (array_wmask),
        .array_wdata         (array_wdata),
        .array_rdata         (array_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Array macro: masked lane writes, registered read data.
    logic [73:0] macro_mem [128];
    initial begin
        for (int i = 0; i < 128; i++) macro_mem[i] = {10'($urandom), $urandom, $urandom};
    end
    always @(posedge clock) begin
        if (array_en) begin
            if (array_wmode) begin
                if (array_wmask[0]) macro_mem[array_addr][36:0]  <= array_wdata[36:0];
                if (array_wmask[1]) macro_mem[array_addr][73:37] <= array_wdata[73:37];
            end else begin
                array_rdata <= macro_mem[array_addr];
            end
        end
    end

    // Reference model: expected contents, queue of returned data, one-cycle pipe of granted reads.
    logic [73:0] ref_mem [128];
    logic [73:0] rq [$];
    logic [73:0] pend [$];
    int          init_cnt = 0;
    int          starve = 0;

    logic        e_wr, e_rr, e_rv, e_done, e_en, e_wm;
    logic [6:0]  e_addr;
    logic [1:0]  e_mask;
    logic [73:0] e_wdata, e_rdata;

    task automatic cmp_all();
        chk("w_ready", 74'(io_w_ready), 74'(e_wr));
        chk("r_req_ready", 74'(io_r_req_ready), 74'(e_rr));
        chk("r_resp_valid", 74'(io_r_resp_valid), 74'(e_rv));
        if (e_rv) chk("r_resp_data", io_r_resp_bits_data, e_rdata);
        chk("init_done", 74'(io_init_done), 74'(e_done));
        chk("array_en", 74'(array_en), 74'(e_en));
        chk("array_wmode", 74'(array_wmode), 74'(e_wm));
        chk("array_addr", 74'(array_addr), 74'(e_addr));
        chk("array_wmask", 74'(array_wmask), 74'(e_mask));
        chk("array_wdata", array_wdata, e_wdata);
    endtask

    always @(negedge clock) begin : model
        int  occ;
        int  busy;
        int  freed;
        bit  can_read, force_w, w_go, r_go;
        e_wr = 0; e_rr = 0; e_rv = 0; e_done = 0; e_en = 0; e_wm = 0;
        e_addr = '0; e_mask = '0; e_wdata = '0; e_rdata = '0;
        if (reset) begin
            cmp_all();
            init_cnt = 0;
            starve = 0;
            rq.delete();
            pend.delete();
        end else if (init_cnt < 128) begin
            e_en = 1; e_wm = 1; e_mask = 2'b11; e_addr = 7'(init_cnt);
            e_rv = (rq.size() != 0);
            if (e_rv) e_rdata = rq[0];
            cmp_all();
            ref_mem[7'(init_cnt)] = '0;
            init_cnt++;
        end else begin
            occ      = rq.size();
            busy     = occ + pend.size();
            freed    = (occ > 0 && io_r_resp_ready) ? 1 : 0;
            can_read = io_r_req_valid && (busy - freed < 2);
            force_w  = io_w_valid && (starve >= 4);
            w_go     = io_w_valid && (!can_read || force_w);
            r_go     = can_read && !w_go;
            e_done = 1;
            e_wr   = w_go;
            e_rr   = r_go;
            e_rv   = (occ != 0);
            if (e_rv) e_rdata = rq[0];
            if (w_go) begin
                e_en = 1; e_wm = 1; e_addr = io_w_bits_addr;
                e_mask = io_w_bits_mask; e_wdata = io_w_bits_data;
            end else if (r_go) begin
                e_en = 1; e_addr = io_r_req_bits_addr;
            end
            cmp_all();
            if (freed == 1) void'(rq.pop_front());
            if (pend.size() != 0) rq.push_back(pend.pop_front());
            if (r_go) pend.push_back(ref_mem[io_r_req_bits_addr]);
            if (w_go) begin
                if (io_w_bits_mask[0]) ref_mem[io_w_bits_addr][36:0]  = io_w_bits_data[36:0];
                if (io_w_bits_mask[1]) ref_mem[io_w_bits_addr][73:37] = io_w_bits_data[73:37];
                starve = 0;
            end else if (io_w_valid && starve < 4) begin
                starve++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [1:0] m, input logic [73:0] d);
        tick();
        io_w_valid = 1; io_w_bits_addr = a; io_w_bits_mask = m; io_w_bits_data = d;
        @(negedge clock);
        chk("wr_granted", 74'(io_w_ready), 74'd1);
        tick();
        io_w_valid = 0;
    endtask

    task automatic do_read(input logic [6:0] a, input logic [73:0] exp, input string name);
        tick();
        io_r_resp_ready = 1; io_r_req_valid = 1; io_r_req_bits_addr = a;
        @(negedge clock);
        chk({name, "_accept"}, 74'(io_r_req_ready), 74'd1);
        tick();
        io_r_req_valid = 0;
        @(negedge clock);
        chk({name, "_not_yet"}, 74'(io_r_resp_valid), 74'd0);
        @(negedge clock);
        chk({name, "_valid"}, 74'(io_r_resp_valid), 74'd1);
        chk({name, "_data"}, io_r_resp_bits_data, exp);
    endtask

    initial begin
        int          cyc, en_cnt, done_at, acc, acc2, grant_at, stale;
        logic        rr_at, last_rdy;
        logic [73:0] pat_a, expd;

        repeat (3) @(posedge clock);
        #1 reset = 0;

        // Clear sweep length and init_done timing.
        cyc = 0; en_cnt = 0; done_at = 0;
        for (int i = 0; i < 200 && done_at == 0; i++) begin
            @(negedge clock);
            cyc++;
            if (io_init_done) done_at = cyc;
            else if (array_en && array_wmode) en_cnt++;
        end
        chk("init_write_cycles", 74'(en_cnt), 74'd128);
        chk("init_done_cycle", 74'(done_at), 74'd129);

        do_read(7'd5, 74'd0, "rd5");

        // Lane-masked writes to the same address.
        pat_a = {2'b10, {18{4'hA}}};
        expd  = {{37{1'b1}}, 1'b0, {9{4'hA}}};
        do_write(7'd3, 2'b01, pat_a);
        do_write(7'd3, 2'b10, '1);
        do_read(7'd3, expd, "rd3_masked");

        // Back-to-back reads, one accept per cycle.
        tick();
        io_r_resp_ready = 1; acc = 0;
        for (int i = 0; i < 16; i++) begin
            io_r_req_valid = 1; io_r_req_bits_addr = 7'(i);
            @(negedge clock);
            if (io_r_req_ready) acc++;
            tick();
        end
        io_r_req_valid = 0;
        chk("b2b_accepts", 74'(acc), 74'd16);
        repeat (4) tick();

        // Full backpressure: two accepts, then stall, then resume.
        io_r_resp_ready = 0; io_r_req_valid = 1; acc = 0; last_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            io_r_req_bits_addr = 7'($urandom_range(0, 15));
            @(negedge clock);
            if (io_r_req_ready) acc++;
            last_rdy = io_r_req_ready;
            tick();
        end
        chk("bp_accepts", 74'(acc), 74'd2);
        chk("bp_ready_low", 74'(last_rdy), 74'd0);
        io_r_resp_ready = 1; acc2 = 0;
        for (int i = 0; i < 4; i++) begin
            io_r_req_bits_addr = 7'($urandom_range(0, 15));
            @(negedge clock);
            if (io_r_req_ready) acc2++;
            tick();
        end
        chk("bp_resume_accepts", 74'(acc2), 74'd4);
        io_r_req_valid = 0;
        repeat (4) tick();

        // Starvation override: write granted on the fifth cycle.
        io_r_req_valid = 1; io_w_valid = 1;
        io_w_bits_addr = 7'd9; io_w_bits_mask = 2'b11;
        io_w_bits_data = {10'($urandom), $urandom, $urandom};
        grant_at = 0; rr_at = 1;
        for (int i = 1; i <= 10 && grant_at == 0; i++) begin
            io_r_req_bits_addr = 7'($urandom_range(0, 15));
            @(negedge clock);
            if (io_w_ready) begin
                grant_at = i;
                rr_at = io_r_req_ready;
            end
            tick();
        end
        io_w_valid = 0; io_r_req_valid = 0;
        chk("starve_grant_cycle", 74'(grant_at), 74'd5);
        chk("starve_read_blocked", 74'(rr_at), 74'd0);
        repeat (4) tick();

        // Reset with one queued response and one read in flight.
        io_r_resp_ready = 0; io_r_req_valid = 1; io_r_req_bits_addr = 7'd3;
        tick();
        tick();
        io_r_req_valid = 0;
        @(negedge clock);
        chk("pre_rst_queued", 74'(io_r_resp_valid), 74'd1);
        tick();
        reset = 1;
        @(negedge clock);
        chk("rst_resp_valid_low", 74'(io_r_resp_valid), 74'd0);
        tick();
        reset = 0; io_r_resp_ready = 1;
        @(negedge clock);
        chk("rst_first_init_cycle", 74'({array_en, array_wmode, array_addr}), 74'({1'b1, 1'b1, 7'd0}));
        stale = 0;
        for (int i = 0; i < 200 && !io_init_done; i++) begin
            if (io_r_resp_valid) stale++;
            @(negedge clock);
        end
        chk("rst_init_done", 74'(io_init_done), 74'd1);
        chk("rst_no_stale_resp", 74'(stale), 74'd0);

        // Randomized traffic over a small address window to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset              = ($urandom_range(0, 599) == 0);
            io_w_valid         = 1'($urandom_range(0, 1));
            io_w_bits_addr     = 7'($urandom_range(0, 15));
            io_w_bits_mask     = 2'($urandom_range(0, 3));
            io_w_bits_data     = {10'($urandom), $urandom, $urandom};
            io_r_req_valid     = 1'($urandom_range(0, 1));
            io_r_req_bits_addr = 7'($urandom_range(0, 15));
            io_r_resp_ready    = ($urandom_range(0, 9) < 7);
        end
        tick();
        reset = 0; io_w_valid = 0; io_r_req_valid = 0; io_r_resp_ready = 1;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
